ucaspian_step_ctrl: RTL

Time-step sequencer for the uCaspian neuron array. Accepts host commands (run N steps, clear activity, clear configuration) over a valid/ready port and drives the neuron's `next_step`, `clear_act` and `clear_config` controls. Advances the global time counter only after the pipeline reports a quiescent `step_done`. Returns a completion record per command.

---
 rtl/ucaspian_step_ctrl.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/ucaspian_step_ctrl.sv
// ucaspian_step_ctrl: time-step sequencer for the uCaspian neuron array.
// Takes RUN / CLEAR_ACT / CLEAR_CFG commands from the host and drives next_step
// and the clear requests to the neurons. cur_time advances only after step_done
// has been high for SETTLE consecutive counted cycles. Each command returns one
// completion record on the done_* port.
// Optional feature: define UCASPIAN_STEP_WATCHDOG_EN to add a WAIT/CLEAR watchdog.
module ucaspian_step_ctrl #(
  parameter int STEP_W      = 16,
  parameter int SETTLE      = 2,
  parameter int WDOG_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_vld,
  output logic              cmd_rdy,
  input  logic [1:0]        cmd_op,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              halt,
  output logic              next_step,
  input  logic              step_done,
  output logic              clear_act,
  output logic              clear_config,
  input  logic              clear_done,
  output logic [STEP_W-1:0] cur_time,
  output logic              done_vld,
  input  logic              done_rdy,
  output logic [STEP_W-1:0] done_steps,
  output logic              done_halted,
  output logic              done_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_PULSE,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_RUN     = 2'd0;
  localparam logic [1:0] OP_CLR_ACT = 2'd1;
  localparam logic [1:0] OP_CLR_CFG = 2'd2;

  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] remaining;
  logic [STEP_W-1:0] executed;
  logic [STEP_W-1:0] time_q;
  logic [3:0]        settle_cnt;
  logic              wait_first;
  logic              halted_q;
  logic              clr_act_q;
  logic              clr_cfg_q;

  logic              clr_pending;
  logic              last_step;
  logic              step_ok;
  logic              stop_run;
  logic              wd_hit;
  logic              wd_abort;

  // A clear request still outstanding; once both drop while in CLEAR the
  // acknowledge has been taken and the next cycle finishes the command.
  assign clr_pending = clr_act_q | clr_cfg_q;
  assign last_step   = (remaining == STEP_W'(1));
  // The first WAIT cycle is skipped because the neuron's flag is still stale.
  assign step_ok     = (state == S_WAIT) && !wait_first && step_done &&
                       (settle_cnt == 4'(SETTLE - 1));
  assign stop_run    = last_step || halt;
  // Step completion and a taken clear acknowledge win over a watchdog expiry.
  assign wd_abort    = wd_hit && (((state == S_WAIT) && !step_ok) ||
                                  ((state == S_CLEAR) && clr_pending && !clear_done));

`ifdef UCASPIAN_STEP_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;

  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  assign wd_hit   = (wd_cnt == WD_W'(WDOG_CYCLES - 1));
  assign done_err = err_q;

  // Watchdog: restart on every state change, count while in WAIT or CLEAR.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_nxt != state) begin
        wd_cnt <= '0;
      end else if ((state == S_WAIT) || (state == S_CLEAR)) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if ((state == S_IDLE) && cmd_vld) begin
        err_q <= 1'b0;
      end else if (wd_abort) begin
        err_q <= 1'b1;
      end
    end
  end
`else
  assign wd_hit   = 1'b0;
  assign done_err = 1'b0;
`endif

  assign cmd_rdy      = (state == S_IDLE);
  assign next_step    = (state == S_PULSE);
  assign done_vld     = (state == S_DONE);
  assign clear_act    = clr_act_q;
  assign clear_config = clr_cfg_q;
  assign cur_time     = time_q;
  assign done_steps   = executed;
  assign done_halted  = halted_q;

  // State register; reset drops next_step and the clear requests immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default assigned before the case so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_vld) begin
          case (cmd_op)
            OP_RUN:               state_nxt = (cmd_steps == '0) ? S_DONE : S_PULSE;
            OP_CLR_ACT, OP_CLR_CFG: state_nxt = S_CLEAR;
            default:              state_nxt = S_DONE;
          endcase
        end
      end
      S_CLEAR: begin
        if (!clr_pending || wd_abort) state_nxt = S_DONE;
      end
      S_PULSE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (step_ok) begin
          state_nxt = stop_run ? S_DONE : S_PULSE;
        end else if (wd_abort) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (done_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: command capture, clear handshake, settle counting, time update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining  <= '0;
      executed   <= '0;
      time_q     <= '0;
      settle_cnt <= '0;
      wait_first <= 1'b0;
      halted_q   <= 1'b0;
      clr_act_q  <= 1'b0;
      clr_cfg_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register here sees pre-edge values.
      case (state)
        S_IDLE: begin
          if (cmd_vld) begin
            remaining <= cmd_steps;
            executed  <= '0;
            halted_q  <= 1'b0;
            clr_act_q <= (cmd_op == OP_CLR_ACT);
            clr_cfg_q <= (cmd_op == OP_CLR_CFG);
          end
        end
        S_CLEAR: begin
          if (clr_pending) begin
            if (clear_done || wd_abort) begin
              clr_act_q <= 1'b0;
              clr_cfg_q <= 1'b0;
            end
          end else begin
            time_q <= '0;
          end
        end
        S_PULSE: begin
          settle_cnt <= '0;
          wait_first <= 1'b1;
        end
        S_WAIT: begin
          wait_first <= 1'b0;
          if (!wait_first) begin
            settle_cnt <= step_done ? (settle_cnt + 4'd1) : 4'd0;
          end
          if (step_ok) begin
            time_q    <= time_q + STEP_W'(1);
            executed  <= executed + STEP_W'(1);
            remaining <= remaining - STEP_W'(1);
            halted_q  <= halt && !last_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
